// File: rtl/mux_select_rr_arbiter_if.sv
// mux_select_rr_arbiter_if: request/release inputs and registered mux-select/grant outputs of the arbiter
interface mux_select_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic       s0;
  logic       s1;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout;
  modport master (output req, done, input s0, s1, grant, grant_valid, timeout);
  modport slave (input req, done, output s0, s1, grant, grant_valid, timeout);
endinterface

// File: rtl/mux_select_rr_arbiter.sv
// mux_select_rr_arbiter: round-robin arbiter driving the 4:1 mux selects with hold-time limited grants
module mux_select_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  mux_select_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [1:0] ptr, sel, pick;
  logic [CNT_W-1:0] cnt;
  logic [3:0] grant;
  logic grant_valid, at_max, release_now;
  assign pick = bus.req[ptr] ? ptr :
                bus.req[ptr + 2'd1] ? ptr + 2'd1 :
                bus.req[ptr + 2'd2] ? ptr + 2'd2 : ptr + 2'd3;
  assign at_max = cnt == CNT_W'(HOLD_MAX - 1);
  assign release_now = bus.done | ~bus.req[sel] | at_max;
  // selects are left untouched outside grant so the mux output stays stable while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      cnt <= '0;
      grant <= '0;
      grant_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (|bus.req) begin
        sel <= pick;
        grant <= 4'b0001 << pick;
        grant_valid <= 1'b1;
        cnt <= '0;
        state <= GRANT;
      end
    end else if (release_now) begin
      state <= IDLE;
      grant <= '0;
      grant_valid <= 1'b0;
      ptr <= sel + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
  assign bus.s1 = sel[1];
  assign bus.s0 = sel[0];
  assign bus.grant = grant;
  assign bus.grant_valid = grant_valid;
  assign bus.timeout = (state == GRANT) & at_max & ~bus.done & bus.req[sel];
endmodule

// File: tb/tb_mux_select_rr_arbiter.sv
// tb_mux_select_rr_arbiter: directed stimulus with a queue of expected grants checked by a monitor
module tb_mux_select_rr_arbiter;
  typedef struct {
    logic [1:0] sel;
    int len;
    int to_cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_q = 1'b0;
  logic fin_req = 1'b0;
  logic fin_ok = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic have = 1'b0;
  logic prev_gv = 1'b0;
  int cyc = 0;
  int to_cyc = 0;
  mux_select_rr_arbiter_if bus ();
  mux_select_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= reset;
  task automatic chk(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req_v, $time);
    end
  endtask
  always @(negedge clk) begin
    if (bus.grant_valid === 1'b1 && !prev_gv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 1, 0);
        have = 1'b0;
      end else begin
        cur = exp_q.pop_front();
        have = 1'b1;
        chk("sel", int'({bus.s1, bus.s0}), int'(cur.sel));
        chk("grant_onehot", int'(bus.grant), int'(4'b0001 << cur.sel));
      end
      cyc = 1;
      to_cyc = bus.timeout ? 1 : 0;
    end else if (bus.grant_valid === 1'b1) begin
      cyc++;
      if (bus.timeout && to_cyc == 0) to_cyc = cyc;
    end else if (prev_gv && have) begin
      chk("grant_len", cyc, cur.len);
      chk("timeout_cycle", to_cyc, cur.to_cyc);
      have = 1'b0;
    end
    if (bus.grant_valid !== 1'b1) begin
      chk("idle_grant", int'(bus.grant), 0);
      chk("idle_timeout", int'(bus.timeout), 0);
    end
    if (rst_q) chk("reset_state", int'({bus.s1, bus.s0, bus.grant_valid, bus.timeout}), 0);
    if (fin_req && !fin_ok) begin
      chk("queue_drained", exp_q.size() + int'(have), 0);
      fin_ok = 1'b1;
    end
    prev_gv = bus.grant_valid === 1'b1;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_grant(input logic [1:0] s, input int len, input int tc);
    exp_q.push_back('{sel: s, len: len, to_cyc: tc});
  endtask
  initial begin
    bus.req = 4'b0000;
    bus.done = 1'b0;
    tick(2);
    reset = 1'b0;
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    // single requester a, released by done
    expect_grant(2'd0, 1, 0);
    bus.req = 4'b0001;
    tick(1);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    bus.req = 4'b0000;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    // all requesting: rotation 0,1,2,3,0 with one idle cycle between grants
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      expect_grant(2'(i), 1, 0);
      tick(1);
      bus.done = 1'b1;
      tick(1);
      bus.done = 1'b0;
    end
    bus.req = 4'b0000;
    tick(1);
    // hold limit on c, then regrant and release by dropping the request
    expect_grant(2'd2, 8, 8);
    expect_grant(2'd2, 1, 0);
    bus.req = 4'b0100;
    tick(1);
    tick(8);
    tick(1);
    bus.req = 4'b0000;
    tick(1);
    // b granted from ptr=3, released by dropping req; ptr=2 so 0011 picks a
    expect_grant(2'd1, 2, 0);
    expect_grant(2'd0, 1, 0);
    bus.req = 4'b0010;
    tick(2);
    bus.req = 4'b0000;
    tick(1);
    bus.req = 4'b0011;
    tick(1);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    bus.req = 4'b0000;
    tick(1);
    // move ptr to 3, then reset mid-grant on d; 1010 must then pick b
    expect_grant(2'd2, 1, 0);
    expect_grant(2'd3, 3, 0);
    expect_grant(2'd1, 1, 0);
    bus.req = 4'b0100;
    tick(1);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    bus.req = 4'b1000;
    tick(1);
    tick(2);
    reset = 1'b1;
    bus.req = 4'b0000;
    tick(1);
    reset = 1'b0;
    bus.req = 4'b1010;
    tick(1);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    bus.req = 4'b0000;
    tick(1);
    // done coinciding with the hold limit: normal release, ptr advances to 1
    expect_grant(2'd0, 8, 0);
    expect_grant(2'd1, 1, 0);
    bus.req = 4'b0001;
    tick(1);
    tick(7);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    bus.req = 4'b0011;
    tick(1);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    bus.req = 4'b0000;
    tick(3);
    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_ok; i++) tick(1);
    if (!fin_ok) begin
      $display("FAIL monitor_stalled: fin_ok=0 expected 1");
      $fatal(1, "monitor stalled");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
